// File: rtl/div_result_bcd_conv.sv
// div_result_bcd_conv
//   Takes the signed quotient/remainder from the divider when it raises done.
//   Each value becomes a sign bit plus a packed-BCD magnitude. The conversion
//   is a sequential double-dabble that handles one bit per cycle. The result
//   is then published with a one-cycle out_valid strobe. A divide-by-zero
//   result skips the conversion and publishes err_out instead.
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous, active-low reset
//     done_in    divider done (level or pulse); its rising edge is the trigger
//     err_in     divider divide-by-zero flag, valid with done_in
//     Q_in/R_in  signed quotient / remainder, N bits two's complement
//     busy       high in every state except IDLE; new triggers are dropped
//     out_valid  one-cycle strobe: the outputs below were just updated
//     q_neg/r_neg       sign of the published Q / R
//     q_bcd/r_bcd       |Q| / |R| as packed BCD, digit 0 in [3:0]
//     err_out    the last published result was divide-by-zero
//
//   Timing: counting the edge that samples the done_in rise as edge 1,
//   out_valid is high after edge 2N+1 for a normal result. For an error
//   result it is high after edge 2.
module div_result_bcd_conv #(
  parameter int N      = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                done_in,
  input  logic                err_in,
  input  logic [N-1:0]        Q_in,
  input  logic [N-1:0]        R_in,
  output logic                busy,
  output logic                out_valid,
  output logic                q_neg,
  output logic [4*DIGITS-1:0] q_bcd,
  output logic                r_neg,
  output logic [4*DIGITS-1:0] r_bcd,
  output logic                err_out
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R, PUBLISH} state_t;

  state_t          state, state_n;
  logic            done_q;
  logic            trig;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   sr;
  logic [SW-1:0]   adj;
  logic [SW-1:0]   step;
  logic [BW-1:0]   q_dig;
  logic [N-1:0]    q_mag;
  logic [N-1:0]    r_mag;
  logic [N-1:0]    r_mag_c;
  logic            err_c;
  logic            neg_q_c;
  logic            neg_r_c;
  logic            last_bit;

  // 2^(N-1) still fits in an N-bit unsigned field, so negating the most
  // negative input cannot overflow here.
  assign q_mag = Q_in[N-1] ? (~Q_in + 1'b1) : Q_in;
  assign r_mag = R_in[N-1] ? (~R_in + 1'b1) : R_in;

  assign trig     = done_in & ~done_q & (state == IDLE);
  assign busy     = (state != IDLE);
  assign last_bit = (cnt == CW'(N - 1));

  // One double-dabble iteration: every BCD digit >= 5 gets +3, then the
  // whole register shifts left by one.
  always_comb begin
    adj = sr;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (sr[N + 4*d +: 4] >= 4'd5)
        adj[N + 4*d +: 4] = sr[N + 4*d +: 4] + 4'd3;
    end
    step = adj << 1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (trig) state_n = err_in ? PUBLISH : CONV_Q;
      CONV_Q:  if (last_bit) state_n = CONV_R;
      CONV_R:  if (last_bit) state_n = PUBLISH;
      PUBLISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q    <= 1'b0;
      cnt       <= '0;
      sr        <= '0;
      q_dig     <= '0;
      r_mag_c   <= '0;
      err_c     <= 1'b0;
      neg_q_c   <= 1'b0;
      neg_r_c   <= 1'b0;
      out_valid <= 1'b0;
      q_neg     <= 1'b0;
      q_bcd     <= '0;
      r_neg     <= 1'b0;
      r_bcd     <= '0;
      err_out   <= 1'b0;
    end else begin
      done_q    <= done_in;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            err_c   <= err_in;
            neg_q_c <= Q_in[N-1];
            neg_r_c <= R_in[N-1];
            r_mag_c <= r_mag;
            sr      <= {{BW{1'b0}}, q_mag};
            cnt     <= '0;
          end
        end
        CONV_Q: begin
          sr  <= step;
          cnt <= cnt + CW'(1);
          if (last_bit) begin
            q_dig <= step[SW-1:N];
            // With an all-zero BCD field the first iteration is a plain
            // shift, so it is folded into the R load. CONV_R then runs the
            // remaining N-1 iterations, which keeps the total latency at
            // 2N+1 edges.
            sr    <= {{(BW-1){1'b0}}, r_mag_c, 1'b0};
            cnt   <= CW'(1);
          end
        end
        CONV_R: begin
          sr  <= step;
          cnt <= cnt + CW'(1);
        end
        PUBLISH: begin
          out_valid <= 1'b1;
          err_out   <= err_c;
          if (err_c) begin
            q_bcd <= '0;
            r_bcd <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
          end else begin
            q_bcd <= q_dig;
            r_bcd <= sr[SW-1:N];
            q_neg <= neg_q_c;
            r_neg <= neg_r_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_result_bcd_conv.sv
module tb_div_result_bcd_conv;

  localparam int N      = 16;
  localparam int DIGITS = 5;
  localparam int LAT_OK  = 2*N + 1;
  localparam int LAT_ERR = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                done_in = 1'b0;
  logic                err_in = 1'b0;
  logic [N-1:0]        Q_in = '0;
  logic [N-1:0]        R_in = '0;
  logic                busy;
  logic                out_valid;
  logic                q_neg;
  logic [4*DIGITS-1:0] q_bcd;
  logic                r_neg;
  logic [4*DIGITS-1:0] r_bcd;
  logic                err_out;

  div_result_bcd_conv #(.N(N), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .done_in(done_in), .err_in(err_in),
    .Q_in(Q_in), .R_in(R_in), .busy(busy), .out_valid(out_valid),
    .q_neg(q_neg), .q_bcd(q_bcd), .r_neg(r_neg), .r_bcd(r_bcd),
    .err_out(err_out)
  );

  always #5 clk = ~clk;

  // Posedges seen so far; read at negedges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [42:0] vec;   // {q_neg, q_bcd, r_neg, r_bcd, err_out}
    int          trig;  // cyc at the negedge where done_in was raised
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic        prev_ov = 1'b0;
  logic [42:0] last_vec = '0;

  // Reference model: decimal digit extraction by division.
  function automatic logic [19:0] bcd(input int v);
    logic [19:0] r;
    int m;
    m = (v < 0) ? -v : v;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Monitor: pops one expectation per strobe.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        checks++;
        if (prev_ov) begin
          errors++;
          $display("FAIL ov_double: out_valid high 2 cycles in a row at cyc %0d", cyc);
        end
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: got %h, expected no strobe (cyc %0d)",
                   {q_neg, q_bcd, r_neg, r_bcd, err_out}, cyc);
        end else begin
          e = sbq.pop_front();
          if ({q_neg, q_bcd, r_neg, r_bcd, err_out} !== e.vec) begin
            errors++;
            $display("FAIL result: got %h, expected %h",
                     {q_neg, q_bcd, r_neg, r_bcd, err_out}, e.vec);
          end
          checks++;
          if (cyc - e.trig != e.lat) begin
            errors++;
            $display("FAIL latency: got %0d, expected %0d", cyc - e.trig, e.lat);
          end
          last_vec = e.vec;
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  // Call at a negedge. Raises done_in for 'hold' cycles. If 'accept' is set,
  // pushes the expected result.
  task automatic issue(input int qv, input int rv, input bit e, input int hold,
                       input bit accept);
    exp_t x;
    Q_in    = qv[15:0];
    R_in    = rv[15:0];
    err_in  = e;
    done_in = 1'b1;
    if (accept) begin
      x.trig = cyc;
      if (e) begin
        x.vec = {1'b0, 20'h0, 1'b0, 20'h0, 1'b1};
        x.lat = LAT_ERR;
      end else begin
        x.vec = {1'(qv < 0), bcd(qv), 1'(rv < 0), bcd(rv), 1'b0};
        x.lat = LAT_OK;
      end
      sbq.push_back(x);
    end
    @(negedge clk);
    if (accept) check_bit("busy_after_trigger", busy, 1'b1);
    repeat (hold - 1) @(negedge clk);
    done_in = 1'b0;
    err_in  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results pending, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    logic [15:0] t;
    int qv, rv;

    // Reset state
    #12;
    checks++;
    if ({busy, out_valid, q_neg, q_bcd, r_neg, r_bcd, err_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {busy, out_valid, q_neg, q_bcd, r_neg, r_bcd, err_out});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed results, issued back-to-back as soon as the DUT is idle
    issue(20, 0, 0, 1, 1);          wait_done();
    issue(-15, 0, 0, 1, 1);         wait_done();
    issue(4, -3, 0, 1, 1);          wait_done();
    issue(-32768, 0, 0, 1, 1);      wait_done();
    issue(32767, 1, 0, 1, 1);       wait_done();
    issue(0, -32768, 0, 1, 1);      wait_done();

    // Divide-by-zero, then a valid result that must clear err_out
    issue(123, 45, 1, 1, 1);        wait_done();
    issue(9, 8, 0, 1, 1);           wait_done();

    // Outputs hold between strobes
    repeat (3) @(negedge clk);
    checks++;
    if ({q_neg, q_bcd, r_neg, r_bcd, err_out} !== last_vec) begin
      errors++;
      $display("FAIL hold: got %h, expected %h",
               {q_neg, q_bcd, r_neg, r_bcd, err_out}, last_vec);
    end

    // done_in held for 10 cycles gives one conversion
    issue(7, -2, 0, 10, 1);         wait_done();

    // A second rise during a conversion is dropped
    issue(20, 0, 0, 1, 1);
    repeat (3) @(negedge clk);
    issue(999, 5, 0, 2, 0);
    wait_done();
    repeat (5) @(negedge clk);

    // Random sweep
    for (int i = 0; i < 8; i++) begin
      t  = 16'($urandom);
      qv = int'($signed(t));
      t  = 16'($urandom);
      rv = int'($signed(t));
      issue(qv, rv, 0, 1, 1);
      wait_done();
    end

    // Leave err_out set, then reset during CONV_R
    issue(1, 1, 1, 1, 1);           wait_done();
    issue(123, 45, 0, 1, 1);
    repeat (19) @(negedge clk);
    sbq.delete();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, out_valid, q_neg, q_bcd, r_neg, r_bcd, err_out} !== '0) begin
      errors++;
      $display("FAIL reset_midconv: got %h, expected 0",
               {busy, out_valid, q_neg, q_bcd, r_neg, r_bcd, err_out});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);     // any strobe here is flagged by the monitor
    check_bit("idle_after_reset", busy, 1'b0);
    issue(-4321, 987, 0, 1, 1);     wait_done();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
